// File: rtl/alu_flags_seq.sv
// rtl/alu_flags_seq.sv - sequential ALU with start/done handshake feeding the status register
// Single-cycle ops finish in IDLE; MUL runs WIDTH shift-add steps in BUSY.
module alu_flags_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             flag_load,
  output logic [WIDTH-1:0] result,
  output logic             z,
  output logic             n,
  output logic             c,
  output logic             v
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [WIDTH-1:0]   result_q;
  logic               z_q, n_q, c_q, v_q;
  logic               done_q, busy_q;

  logic [WIDTH:0]     wide_d;
  logic [WIDTH-1:0]   alu_r_d;
  logic               alu_c_d, alu_v_d;
  logic [2*WIDTH-1:0] acc_d;

  always_comb begin
    wide_d  = '0;
    alu_r_d = '0;
    alu_c_d = 1'b0;
    alu_v_d = 1'b0;
    case (op)
      OP_ADD: begin
        wide_d  = {1'b0, a} + {1'b0, b};
        alu_r_d = wide_d[WIDTH-1:0];
        alu_c_d = wide_d[WIDTH];
        alu_v_d = (a[WIDTH-1] == b[WIDTH-1]) && (alu_r_d[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        // Carry is the inverted borrow: set when a >= b unsigned.
        wide_d  = {1'b0, a} - {1'b0, b};
        alu_r_d = wide_d[WIDTH-1:0];
        alu_c_d = ~wide_d[WIDTH];
        alu_v_d = (a[WIDTH-1] != b[WIDTH-1]) && (alu_r_d[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: alu_r_d = a & b;
      OP_OR:  alu_r_d = a | b;
      OP_XOR: alu_r_d = a ^ b;
      OP_NOT: alu_r_d = ~a;
      OP_SHL: begin
        alu_r_d = {a[WIDTH-2:0], 1'b0};
        alu_c_d = a[WIDTH-1];
      end
      default: ;
    endcase
  end

  assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      result_q <= '0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (op == OP_MUL) begin
              mcand_q  <= {{WIDTH{1'b0}}, a};
              mplier_q <= b;
              acc_q    <= '0;
              cnt_q    <= CNT_INIT;
              busy_q   <= 1'b1;
              state_q  <= S_BUSY;
            end else begin
              result_q <= alu_r_d;
              z_q      <= (alu_r_d == '0);
              n_q      <= alu_r_d[WIDTH-1];
              c_q      <= alu_c_d;
              v_q      <= alu_v_d;
              done_q   <= 1'b1;
            end
          end
        end
        S_BUSY: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q - CNT_ONE;
          // Last step: acc_d already holds the full product.
          if (cnt_q == CNT_ONE) begin
            result_q <= acc_d[WIDTH-1:0];
            z_q      <= (acc_d[WIDTH-1:0] == '0);
            n_q      <= acc_d[WIDTH-1];
            c_q      <= |acc_d[2*WIDTH-1:WIDTH];
            v_q      <= 1'b0;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign flag_load = done_q;
  assign result    = result_q;
  assign z         = z_q;
  assign n         = n_q;
  assign c         = c_q;
  assign v         = v_q;

endmodule

// File: tb/tb_alu_flags_seq.sv
// tb/tb_alu_flags_seq.sv - self-checking bench for alu_flags_seq
// Transaction-level reference model plus directed literal cases and random traffic.
module tb_alu_flags_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, flag_load, z, n, c, v;
  logic [W-1:0] result;

  int n_checks = 0;
  int n_fail = 0;

  alu_flags_seq #(.WIDTH(W), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .flag_load(flag_load), .result(result),
    .z(z), .n(n), .c(c), .v(v)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Returns {z,n,c,v,result} from plain integer arithmetic.
  function automatic logic [11:0] ref_alu(input int o, input int x, input int y);
    int r, sx, sy, s;
    logic cf, vf;
    logic [7:0] r8;
    cf = 1'b0; vf = 1'b0; r = 0;
    sx = (x >= 128) ? x - 256 : x;
    sy = (y >= 128) ? y - 256 : y;
    case (o)
      0: begin r = x + y; cf = (r > 255); s = sx + sy; vf = (s > 127) || (s < -128); end
      1: begin r = x - y; cf = (x >= y);  s = sx - sy; vf = (s > 127) || (s < -128); end
      2: r = x & y;
      3: r = x | y;
      4: r = x ^ y;
      5: r = 255 - x;
      6: begin r = x * 2; cf = (x >= 128); end
      default: begin r = x * y; cf = (r > 255); end
    endcase
    r8 = r[7:0];
    return {(r8 == 8'd0), r8[7], cf, vf, r8};
  endfunction

  int          cyc = 0;
  int          busy_last = -1;
  int          done_iv = -1;
  logic [11:0] pend = '0;
  logic [11:0] exp_out = '0;
  logic        exp_busy = 1'b0;
  logic        exp_done = 1'b0;

  // Interval e is the clock period following rising edge e.
  always @(posedge clk or negedge rst_n) begin : mdl
    int e, bl, di;
    logic [11:0] pd;
    if (!rst_n) begin
      busy_last <= -1;
      done_iv   <= -1;
      exp_busy  <= 1'b0;
      exp_done  <= 1'b0;
      exp_out   <= '0;
    end else begin
      e = cyc + 1; bl = busy_last; di = done_iv; pd = pend;
      if (start && !(e - 1 <= bl)) begin
        pd = ref_alu(int'(op), int'(a), int'(b));
        if (op == 3'd7) begin
          bl = e + W - 1;
          di = e + W;
        end else begin
          di = e;
        end
      end
      cyc       <= e;
      busy_last <= bl;
      done_iv   <= di;
      pend      <= pd;
      exp_busy  <= (e <= bl);
      exp_done  <= (e == di);
      if (e == di) exp_out <= pd;
    end
  end

  always @(negedge clk) begin
    chk("busy", busy, exp_busy);
    chk("done", done, exp_done);
    chk("flag_load", flag_load, exp_done);
    chk("flags_result", {z, n, c, v, result}, exp_out);
  end

  task automatic expect_op(input string nm, input logic [2:0] o, input logic [7:0] x,
                           input logic [7:0] y, input logic [7:0] er, input logic [3:0] ef,
                           input int elat, input int ebusy);
    int lat, nb;
    lat = 0; nb = 0;
    @(posedge clk); #1;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      lat++;
      if (busy) nb++;
      if (done) break;
    end
    chk({nm, "_lat"}, lat, elat);
    chk({nm, "_busy_cycles"}, nb, ebusy);
    chk({nm, "_result"}, result, er);
    chk({nm, "_zncv"}, {z, n, c, v}, ef);
    @(negedge clk);
    chk({nm, "_done_one_cycle"}, done, 1'b0);
  endtask

  initial begin
    int lat, dcount;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_result", result, 8'h00);
    chk("reset_zncv", {z, n, c, v}, 4'b0000);
    chk("reset_busy_done", {busy, done, flag_load}, 3'b000);

    // Abort a MUL in its third busy cycle.
    @(posedge clk); #1;
    start = 1'b1; op = 3'd7; a = 8'h0C; b = 8'h0B;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 1'b0);
    chk("abort_result", {z, n, c, v, result}, 12'h000);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    dcount = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("abort_no_done", dcount, 0);
    expect_op("add_1_1", 3'd0, 8'h01, 8'h01, 8'h02, 4'b0000, 1, 0);

    expect_op("add_7f_01", 3'd0, 8'h7F, 8'h01, 8'h80, 4'b0101, 1, 0);
    expect_op("add_ff_01", 3'd0, 8'hFF, 8'h01, 8'h00, 4'b1010, 1, 0);
    expect_op("sub_05_05", 3'd1, 8'h05, 8'h05, 8'h00, 4'b1010, 1, 0);
    expect_op("sub_03_05", 3'd1, 8'h03, 8'h05, 8'hFE, 4'b0100, 1, 0);
    expect_op("and_f0_0f", 3'd2, 8'hF0, 8'h0F, 8'h00, 4'b1000, 1, 0);
    expect_op("shl_81", 3'd6, 8'h81, 8'h00, 8'h02, 4'b0010, 1, 0);
    expect_op("not_00", 3'd5, 8'h00, 8'h00, 8'hFF, 4'b0100, 1, 0);
    expect_op("mul_0c_0b", 3'd7, 8'h0C, 8'h0B, 8'h84, 4'b0100, 9, 8);
    expect_op("mul_10_10", 3'd7, 8'h10, 8'h10, 8'h00, 4'b1010, 9, 8);

    // ADD held on start during MUL is ignored, then accepted in the done cycle.
    @(posedge clk); #1;
    start = 1'b1; op = 3'd7; a = 8'h0C; b = 8'h0B;
    @(posedge clk); #1;
    op = 3'd0; a = 8'h02; b = 8'h03;
    lat = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      lat++;
      if (done) break;
    end
    chk("hs_mul_lat", lat, 9);
    chk("hs_mul_result", result, 8'h84);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("hs_add_done", done, 1'b1);
    chk("hs_add_result", {z, n, c, v, result}, 12'h005);

    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      op = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
      @(negedge clk);
      chk("hold_result", {z, n, c, v, result}, 12'h005);
      chk("hold_done", done, 1'b0);
    end

    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 2) != 0);
      op = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
      if (i % 7 == 0) begin a = 8'h80; b = 8'hFF; end
    end
    @(posedge clk); #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_flags_seq.md
Name: alu_flags_seq

Overview:
- Sequential ALU directly upstream of the processor status register.
- Takes operands and an opcode with a start/done handshake.
- Single-cycle ops complete in one cycle; MUL uses an iterative shift-add multiplier.
- Produces a registered result, Z/N/C/V flags and a one-cycle flag-load strobe that feed the status register's z, n, c, v and load inputs.

Parameters:
WIDTH, 8, operand/result width in bits (>=4)
CNT_W, 4, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  in  1  system clock, rising-edge
rst_n  in  1  reset, asynchronous, active-low
start  in  1  request; accepted only when busy=0
op  in  3  opcode, sampled on acceptance
a  in  WIDTH  operand A, sampled on acceptance
b  in  WIDTH  operand B, sampled on acceptance
busy  out  1  1 while a MUL is iterating
done  out  1  one-cycle pulse, result/flags valid
flag_load  out  1  equals done; drives status register load
result  out  WIDTH  registered result, held until next done
z  out  1  zero flag
n  out  1  negative flag
c  out  1  carry flag
v  out  1  overflow flag

Behaviour:
- Reset value of every output: result=0, z=n=c=v=0, done=flag_load=0, busy=0. FSM goes to IDLE and the counter clears.
- Reset asserted mid-operation aborts the op; no done is produced.
- FSM states:
  - IDLE: on an edge with start=1 and op!=MUL, compute and register result/flags, set done=1 for the next cycle, stay in IDLE.
  - IDLE: on an edge with start=1 and op=MUL, latch a/b into multiplicand/multiplier regs, clear the 2*WIDTH accumulator, set cnt=WIDTH, go to BUSY.
  - BUSY: each edge performs one shift-add step and decrements cnt.
  - BUSY, edge where cnt goes 1->0: register result and flags, pulse done, go to IDLE.
- Latency: non-MUL done is asserted the cycle after acceptance (1). MUL: busy is high for WIDTH cycles and done is asserted WIDTH+1 cycles after acceptance.
- start while busy=1 is ignored; the in-flight op is unaffected and no queueing occurs.
- start in the cycle where done=1 is accepted, since the FSM is in IDLE. Back-to-back ops are legal.
- done and flag_load pulse exactly one cycle per accepted op. result and flags hold their values between pulses.
- Opcodes:
  - 000 ADD: r=a+b; c=carry out; v=signed overflow.
  - 001 SUB: r=a-b; c=1 iff a>=b unsigned (no borrow); v=signed overflow.
  - 010 AND, 011 OR, 100 XOR: c=0, v=0.
  - 101 NOT: r=~a; c=0, v=0.
  - 110 SHL: r=a<<1; c=a[WIDTH-1]; v=0.
  - 111 MUL: unsigned; r=low WIDTH bits of the product; c=1 iff the high WIDTH bits are nonzero; v=0.
- For all ops: z=(r==0), n=r[WIDTH-1], both computed on the WIDTH-bit result.
- Arithmetic is internally WIDTH+1 bits for ADD/SUB and 2*WIDTH for the MUL accumulator; there are no X-producing paths.

Test Plan:
- Reset: hold rst_n=0 mid-MUL (cycle 3 of BUSY), release -> busy=0, done never pulses, result=0 and flags=0. The next ADD 0x01+0x01 gives result 0x02 with done 1 cycle later.
- ADD/SUB flags (WIDTH=8):
  - ADD 0x7F+0x01 -> 0x80, n=1 v=1 c=0 z=0.
  - ADD 0xFF+0x01 -> 0x00, z=1 c=1 v=0.
  - SUB 0x05-0x05 -> 0x00, z=1 c=1 n=0 v=0.
  - SUB 0x03-0x05 -> 0xFE, n=1 c=0.
- Logic/shift:
  - AND 0xF0&0x0F -> 0x00, z=1 c=0 v=0.
  - SHL 0x81 -> 0x02, c=1 n=0.
  - NOT 0x00 -> 0xFF, n=1.
- MUL timing:
  - MUL 0x0C*0x0B -> 0x84, c=0 n=1. busy high exactly 8 cycles, done/flag_load high exactly 1 cycle, 9 cycles after acceptance.
  - MUL 0x10*0x10 -> 0x00, z=1 c=1.
- Handshake: start=1 with ADD inputs during MUL busy -> ignored, and the MUL result is unchanged. start ADD 0x02+0x03 in the MUL done cycle -> accepted, done next cycle with result 0x05.
- Hold: after done, toggle a/b/op with start=0 for 5 cycles -> result and flags unchanged, done=0.
